// File: rtl/cpu_mc_pkg.sv
// ============================================================================
//  cpu_mc_pkg : opcodes, FSM state encoding, ALU ops and flag indices
//  Revision   : 1.0
// ============================================================================
`default_nettype none

package cpu_mc_pkg;

    localparam int OP_HLT  = 0;
    localparam int OP_STO  = 1;
    localparam int OP_LD   = 2;
    localparam int OP_LDI  = 3;
    localparam int OP_ADD  = 4;
    localparam int OP_ADDI = 5;
    localparam int OP_SUB  = 6;
    localparam int OP_SUBI = 7;
    localparam int OP_AND  = 8;
    localparam int OP_OR   = 9;
    localparam int OP_XOR  = 10;
    localparam int OP_JMP  = 11;
    localparam int OP_BEQ  = 12;
    localparam int OP_BNE  = 13;
    localparam int OP_BLT  = 14;
    localparam int OP_BCS  = 15;

    localparam int FLAG_Z    = 0;
    localparam int FLAG_N    = 1;
    localparam int FLAG_C    = 2;
    localparam int NUM_FLAGS = 3;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5
    } alu_op_t;

endpackage

`default_nettype wire

// File: rtl/cpu_mc_alu.sv
// ============================================================================
//  cpu_mc_alu : combinational ALU, result plus Z/N and carry/borrow
//  Revision   : 1.0
// ============================================================================
`default_nettype none

module cpu_mc_alu
    import cpu_mc_pkg::*;
#(
    parameter int DATASIZE = 16
) (
    input  alu_op_t             op,
    input  logic [DATASIZE-1:0] a,
    input  logic [DATASIZE-1:0] b,
    output logic [DATASIZE-1:0] result,
    output logic                zero,
    output logic                neg,
    output logic                carry
);

    logic [DATASIZE:0] wide;

    // The extra top bit of the widened sum/difference is carry-out / borrow.
    always_comb begin
        wide   = '0;
        result = b;
        carry  = 1'b0;
        case (op)
            ALU_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATASIZE-1:0];
                carry  = wide[DATASIZE];
            end
            ALU_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATASIZE-1:0];
                carry  = wide[DATASIZE];
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = b;
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[DATASIZE-1];

endmodule

`default_nettype wire

// File: rtl/cpu_mc.sv
// ============================================================================
//  cpu_mc : multi-cycle accumulator core (FETCH/EXEC/MEM/HALT)
//  Revision   : 1.0
// ============================================================================
`default_nettype none

module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter int DATASIZE = 16,
    parameter int ADDRSIZE = 11
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [DATASIZE-1:0] romData_i,
    output logic [ADDRSIZE-1:0] romAddr_o,
    input  logic [DATASIZE-1:0] ramData_i,
    input  logic                ramAck_i,
    output logic [DATASIZE-1:0] ramData_o,
    output logic [ADDRSIZE-1:0] ramAddr_o,
    output logic                wrRam_o,
    output logic                rdRam_o,
    output logic                halted_o,
    output logic [DATASIZE-1:0] acc_o
);

    localparam int OPSIZE = DATASIZE - ADDRSIZE;

    state_t                 state, state_nx;
    logic [ADDRSIZE-1:0]    pc, pc_nx;
    logic [DATASIZE-1:0]    ir, ir_nx, acc, acc_nx;
    logic [NUM_FLAGS-1:0]   flags, flags_nx;

    logic [DATASIZE-1:0]    instr, imm, alu_b, alu_result;
    logic [OPSIZE-1:0]      opcode;
    logic [ADDRSIZE-1:0]    operand;
    logic [31:0]            opc;
    logic                   alu_z, alu_n, alu_c;
    alu_op_t                alu_op;
    logic                   wr_acc, set_c, mem_op, mem_wr, jump, halt;
    logic                   commit, rd, wr;

    // EXEC decodes the word straight off the ROM bus; MEM decodes the latched copy.
    assign instr   = (state == S_EXEC) ? romData_i : ir;
    assign opcode  = instr[DATASIZE-1:ADDRSIZE];
    assign operand = instr[ADDRSIZE-1:0];
    assign opc     = 32'(opcode);
    assign imm     = {{OPSIZE{operand[ADDRSIZE-1]}}, operand};
    assign alu_b   = (state == S_MEM) ? ramData_i : imm;

    always_comb begin
        alu_op = ALU_PASS;
        wr_acc = 1'b0;
        set_c  = 1'b0;
        mem_op = 1'b0;
        mem_wr = 1'b0;
        jump   = 1'b0;
        halt   = 1'b0;
        case (opc)
            OP_HLT:  halt = 1'b1;
            OP_STO:  begin mem_op = 1'b1; mem_wr = 1'b1; end
            OP_LD:   begin mem_op = 1'b1; wr_acc = 1'b1; end
            OP_LDI:  wr_acc = 1'b1;
            OP_ADD:  begin mem_op = 1'b1; wr_acc = 1'b1; alu_op = ALU_ADD; set_c = 1'b1; end
            OP_ADDI: begin wr_acc = 1'b1; alu_op = ALU_ADD; set_c = 1'b1; end
            OP_SUB:  begin mem_op = 1'b1; wr_acc = 1'b1; alu_op = ALU_SUB; set_c = 1'b1; end
            OP_SUBI: begin wr_acc = 1'b1; alu_op = ALU_SUB; set_c = 1'b1; end
            OP_AND:  begin mem_op = 1'b1; wr_acc = 1'b1; alu_op = ALU_AND; end
            OP_OR:   begin mem_op = 1'b1; wr_acc = 1'b1; alu_op = ALU_OR;  end
            OP_XOR:  begin mem_op = 1'b1; wr_acc = 1'b1; alu_op = ALU_XOR; end
            OP_JMP:  jump = 1'b1;
            OP_BEQ:  jump = flags[FLAG_Z];
            OP_BNE:  jump = ~flags[FLAG_Z];
            OP_BLT:  jump = flags[FLAG_N];
            OP_BCS:  jump = flags[FLAG_C];
            default: ;
        endcase
    end

    cpu_mc_alu #(
        .DATASIZE (DATASIZE)
    ) u_alu (
        .op     (alu_op),
        .a      (acc),
        .b      (alu_b),
        .result (alu_result),
        .zero   (alu_z),
        .neg    (alu_n),
        .carry  (alu_c)
    );

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir;
        acc_nx   = acc;
        flags_nx = flags;
        commit   = 1'b0;
        rd       = 1'b0;
        wr       = 1'b0;
        case (state)
            S_FETCH: state_nx = S_EXEC;
            S_EXEC: begin
                ir_nx = romData_i;
                if (halt) begin
                    state_nx = S_HALT;
                end else if (mem_op) begin
                    state_nx = S_MEM;
                end else begin
                    commit   = 1'b1;
                    pc_nx    = jump ? operand : pc + ADDRSIZE'(1);
                    state_nx = S_FETCH;
                end
            end
            S_MEM: begin
                rd = ~mem_wr;
                wr = mem_wr;
                if (ramAck_i) begin
                    commit   = 1'b1;
                    pc_nx    = pc + ADDRSIZE'(1);
                    state_nx = S_FETCH;
                end
            end
            default: ;
        endcase
        if (commit && wr_acc) begin
            acc_nx         = alu_result;
            flags_nx[FLAG_Z] = alu_z;
            flags_nx[FLAG_N] = alu_n;
            if (set_c) flags_nx[FLAG_C] = alu_c;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
            acc   <= '0;
            flags <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            ir    <= ir_nx;
            acc   <= acc_nx;
            flags <= flags_nx;
        end
    end

    // Reset masks the bus outputs combinationally so an in-flight access drops at once.
    assign rdRam_o   = rd & ~reset_i;
    assign wrRam_o   = wr & ~reset_i;
    assign ramAddr_o = (state == S_MEM && !reset_i) ? ir[ADDRSIZE-1:0] : '0;
    assign ramData_o = acc;
    assign romAddr_o = reset_i ? '0 : pc;
    assign halted_o  = (state == S_HALT) & ~reset_i;
    assign acc_o     = acc;

endmodule

`default_nettype wire

// File: tb/tb_cpu_mc.sv
// ============================================================================
//  tb_cpu_mc : directed self-checking bench for cpu_mc with ROM/RAM models
//  Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_mc;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [15:0] romData_i = '0;
    logic [10:0] romAddr_o;
    logic [15:0] ramData_i;
    logic        ramAck_i;
    logic [15:0] ramData_o;
    logic [10:0] ramAddr_o;
    logic        wrRam_o, rdRam_o, halted_o;
    logic [15:0] acc_o;

    logic [15:0] rom [2048];
    logic [15:0] ram [2048];
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic        force_ack = 1'b0;
    int          wr_count  = 0;
    logic [10:0] wr_addr   = '0;
    logic [15:0] wr_data   = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_mc #(.DATASIZE(16), .ADDRSIZE(11)) dut (
        .clock_i   (clk),
        .reset_i   (reset_i),
        .romData_i (romData_i),
        .romAddr_o (romAddr_o),
        .ramData_i (ramData_i),
        .ramAck_i  (ramAck_i),
        .ramData_o (ramData_o),
        .ramAddr_o (ramAddr_o),
        .wrRam_o   (wrRam_o),
        .rdRam_o   (rdRam_o),
        .halted_o  (halted_o),
        .acc_o     (acc_o)
    );

    always @(posedge clk) romData_i <= rom[romAddr_o];

    always_comb begin
        ramData_i = ram[ramAddr_o];
        ramAck_i  = force_ack || ((rdRam_o || wrRam_o) && (wait_cnt >= ack_delay));
    end

    always @(posedge clk) begin
        if (!(rdRam_o || wrRam_o) || ramAck_i) wait_cnt <= 0;
        else                                   wait_cnt <= wait_cnt + 1;
        if (wrRam_o && ramAck_i) begin
            wr_count <= wr_count + 1;
            wr_addr  <= ramAddr_o;
            wr_data  <= ramData_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ins(input int op, input int opd);
        return {op[4:0], opd[10:0]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        #1;
        check("rst_rd",      32'(rdRam_o),   0);
        check("rst_wr",      32'(wrRam_o),   0);
        check("rst_halted",  32'(halted_o),  0);
        check("rst_romaddr", 32'(romAddr_o), 0);
        check("rst_ramaddr", 32'(ramAddr_o), 0);
        tick(1);
        tick(1);
        reset_i = 1'b0;
        check("post_rst_acc",     32'(acc_o),     0);
        check("post_rst_romaddr", 32'(romAddr_o), 0);
        check("post_rst_rd",      32'(rdRam_o),   0);
        check("post_rst_halted",  32'(halted_o),  0);
    endtask

    int          wr_base;
    logic [15:0] exp_acc [6];

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 16'h0000;
        clear_rom();
        tick(1);

        // LDI 5; ADDI 3; STO 0x010; HLT with zero-wait ack
        rom[0] = ins(3, 5);
        rom[1] = ins(5, 3);
        rom[2] = ins(1, 'h010);
        rom[3] = ins(0, 0);
        ack_delay = 0;
        do_reset();
        wr_base = wr_count;
        tick(2); check("t1_acc_ldi",  32'(acc_o), 5);
        tick(2); check("t1_acc_addi", 32'(acc_o), 8);
        tick(2);
        check("t1_wr_req",   32'(wrRam_o),   1);
        check("t1_rd_req",   32'(rdRam_o),   0);
        check("t1_ramaddr",  32'(ramAddr_o), 'h010);
        check("t1_ramdata",  32'(ramData_o), 8);
        tick(1);
        check("t1_wr_addr",  32'(wr_addr),   'h010);
        check("t1_wr_data",  32'(wr_data),   8);
        check("t1_wr_idle",  32'(wrRam_o),   0);
        tick(1); check("t1_not_halted", 32'(halted_o), 0);
        tick(1); check("t1_halted",     32'(halted_o), 1);
        check("t1_acc_final", 32'(acc_o), 8);
        tick(3);
        check("t1_pc_frozen", 32'(romAddr_o), 3);
        check("t1_halt_hold", 32'(halted_o),  1);
        check("t1_no_req",    32'(rdRam_o | wrRam_o), 0);
        check("t1_one_write", 32'(wr_count - wr_base), 1);

        // Carry, zero and borrow/negative via branches
        clear_rom();
        rom['h000] = ins(3, 'h7FF);
        rom['h001] = ins(5, 1);
        rom['h002] = ins(12, 'h010);
        rom['h010] = ins(15, 'h020);
        rom['h020] = ins(7, 1);
        rom['h021] = ins(14, 'h030);
        rom['h030] = ins(15, 'h040);
        rom['h040] = ins(12, 'h050);
        rom['h041] = ins(0, 0);
        do_reset();
        tick(2);  check("t2_ldi_m1",   32'(acc_o),     'hFFFF);
        tick(2);  check("t2_addi_wrap", 32'(acc_o),    0);
        tick(2);  check("t2_beq_z",    32'(romAddr_o), 'h010);
        tick(2);  check("t2_bcs_c",    32'(romAddr_o), 'h020);
        tick(2);  check("t2_subi",     32'(acc_o),     'hFFFF);
        tick(2);  check("t2_blt_n",    32'(romAddr_o), 'h030);
        tick(2);  check("t2_bcs_borrow", 32'(romAddr_o), 'h040);
        tick(2);  check("t2_beq_nz",   32'(romAddr_o), 'h041);

        // LD with ack in the third MEM cycle
        clear_rom();
        ram['h020] = 16'h1234;
        rom[0] = ins(2, 'h020);
        ack_delay = 2;
        do_reset();
        tick(2);
        check("t3_rd_c1",   32'(rdRam_o),   1);
        check("t3_addr",    32'(ramAddr_o), 'h020);
        check("t3_wr_low",  32'(wrRam_o),   0);
        tick(1); check("t3_rd_c2", 32'(rdRam_o), 1);
        tick(1); check("t3_rd_c3", 32'(rdRam_o), 1);
        check("t3_acc_wait", 32'(acc_o), 0);
        tick(1);
        check("t3_rd_done", 32'(rdRam_o),   0);
        check("t3_acc",     32'(acc_o),     'h1234);
        check("t3_pc",      32'(romAddr_o), 1);

        // Memory-operand ALU ops, zero-wait
        clear_rom();
        ram['h030] = 16'h00F0;
        rom[0] = ins(3, 'h0FF);
        rom[1] = ins(4, 'h030);
        rom[2] = ins(10, 'h030);
        rom[3] = ins(9, 'h030);
        rom[4] = ins(8, 'h030);
        rom[5] = ins(6, 'h030);
        rom[6] = ins(12, 9);
        exp_acc[0] = 16'h00FF;
        exp_acc[1] = 16'h01EF;
        exp_acc[2] = 16'h011F;
        exp_acc[3] = 16'h01FF;
        exp_acc[4] = 16'h00F0;
        exp_acc[5] = 16'h0000;
        ack_delay = 0;
        do_reset();
        tick(2);
        check("t4_acc0", 32'(acc_o), 32'(exp_acc[0]));
        for (int i = 1; i < 6; i++) begin
            tick(3);
            check($sformatf("t4_acc%0d", i), 32'(acc_o), 32'(exp_acc[i]));
        end
        tick(2); check("t4_beq_after_sub", 32'(romAddr_o), 9);

        // Branch taken / not taken at pc=5, pc wrap past 0x7FF
        clear_rom();
        rom['h000] = ins(3, 0);
        rom['h001] = ins(11, 5);
        rom['h005] = ins(12, 'h100);
        rom['h100] = ins(3, 1);
        rom['h101] = ins(11, 5);
        rom['h006] = ins(11, 'h7FF);
        rom['h7FF] = ins(12, 'h123);
        do_reset();
        tick(4);  check("t5_jmp5",      32'(romAddr_o), 5);
        tick(2);  check("t5_beq_taken", 32'(romAddr_o), 'h100);
        tick(4);  check("t5_back5",     32'(romAddr_o), 5);
        tick(2);  check("t5_beq_not",   32'(romAddr_o), 6);
        tick(2);  check("t5_jmp_top",   32'(romAddr_o), 'h7FF);
        tick(2);  check("t5_pc_wrap",   32'(romAddr_o), 0);

        // Reset while a read is waiting; late ack must be dropped
        clear_rom();
        rom[0] = ins(2, 'h020);
        ack_delay = 20;
        do_reset();
        tick(2);
        check("t6_rd_wait", 32'(rdRam_o), 1);
        reset_i = 1'b1;
        #1;
        check("t6_rd_in_rst",   32'(rdRam_o),   0);
        check("t6_addr_in_rst", 32'(ramAddr_o), 0);
        tick(1);
        reset_i   = 1'b0;
        force_ack = 1'b1;
        check("t6_rd_after",  32'(rdRam_o),   0);
        check("t6_pc_after",  32'(romAddr_o), 0);
        tick(1);
        force_ack = 1'b0;
        check("t6_acc_late_ack", 32'(acc_o),   0);
        check("t6_no_req_exec",  32'(rdRam_o), 0);
        tick(1);
        check("t6_refetch_ld", 32'(rdRam_o), 1);
        check("t6_acc_hold",   32'(acc_o),   0);
        ack_delay = 0;

        // Undefined opcode 20 at pc=3 behaves as NOP
        clear_rom();
        rom['h000] = ins(3, 'h7FF);
        rom['h001] = ins(5, 1);
        rom['h002] = ins(3, 'h400);
        rom['h003] = ins(20, 'h7FF);
        rom['h004] = ins(14, 'h010);
        rom['h010] = ins(15, 'h020);
        rom['h020] = ins(13, 'h030);
        do_reset();
        tick(6);  check("t7_acc_pre",  32'(acc_o),     'hFC00);
        check("t7_pc3", 32'(romAddr_o), 3);
        tick(2);
        check("t7_nop_pc",  32'(romAddr_o), 4);
        check("t7_nop_acc", 32'(acc_o),     'hFC00);
        tick(2);  check("t7_n_kept",  32'(romAddr_o), 'h010);
        tick(2);  check("t7_c_kept",  32'(romAddr_o), 'h020);
        tick(2);  check("t7_nz_kept", 32'(romAddr_o), 'h030);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_mc.md
CPU_MC -- requirements
Module: cpu_mc

Interface
REQ-001 SHALL have parameter DATASIZE, default 16: instruction, accumulator and RAM data width.
REQ-002 SHALL have parameter ADDRSIZE, default 11: ROM/RAM address and operand width; opcode field OPSIZE = DATASIZE-ADDRSIZE (≥4) is derived.
REQ-003 SHALL have one clock and a synchronous active-high reset; ports follow.
REQ-004 clock_i  in  1  sole clock, rising edge.
REQ-005 reset_i  in  1  synchronous reset, active high.
REQ-006 romData_i  in  DATASIZE  instruction word, valid one cycle after romAddr_o.
REQ-007 romAddr_o  out  ADDRSIZE  program counter.
REQ-008 ramData_i  in  DATASIZE  read data, valid in ramAck_i cycle.
REQ-009 ramAck_i  in  1  RAM completes current access.
REQ-010 ramData_o / ramAddr_o  out  DATASIZE / ADDRSIZE  store data (accumulator) / access address.
REQ-011 wrRam_o / rdRam_o  out  1 / 1  write / read request, held until ramAck_i.
REQ-012 halted_o  out  1  core is in HALT.
REQ-013 acc_o  out  DATASIZE  accumulator, debug.

Function
REQ-014 Instruction = {opcode[DATASIZE-1:ADDRSIZE], operand[ADDRSIZE-1:0]}; immediates sign-extended to DATASIZE.
REQ-015 Opcodes: 0 HLT, 1 STO, 2 LD, 3 LDI, 4 ADD, 5 ADDI, 6 SUB, 7 SUBI, 8 AND, 9 OR, 10 XOR, 11 JMP, 12 BEQ(Z), 13 BNE(!Z), 14 BLT(N), 15 BCS(C); all others NOP.
REQ-016 FSM states FETCH, EXEC, MEM, HALT; FETCH drives romAddr_o=pc, always -> EXEC.
REQ-017 EXEC latches romData_i into ir; register/immediate ops, jumps and NOP complete there, pc updates, -> FETCH (CPI 2).
REQ-018 LD/ADD/SUB/AND/OR/XOR with memory operand and STO: EXEC -> MEM; MEM asserts rdRam_o (or wrRam_o) with ramAddr_o=operand until ramAck_i, then completes, pc+1, -> FETCH (CPI 2+wait cycles; ack in first MEM cycle gives CPI 3).
REQ-019 wrRam_o and rdRam_o never both high; both low outside MEM.
REQ-020 ramAck_i outside MEM ignored.
REQ-021 Arithmetic mod 2^DATASIZE; Z = result==0, N = result MSB; C = carry-out on ADD/ADDI, borrow (unsigned a<b) on SUB/SUBI, unchanged otherwise.
REQ-022 Z,N updated by every op writing acc; STO, branches, NOP, HLT leave flags unchanged.
REQ-023 Taken branch/JMP: pc = operand; not taken: pc+1; pc wraps 2^ADDRSIZE-1 -> 0.
REQ-024 HLT: -> HALT, pc frozen, halted_o=1, no RAM request; exit only by reset.

Reset
REQ-025 reset_i=1 at a rising edge: state=FETCH, pc=0, ir=0, acc=0, Z=C=N=0 by next edge.
REQ-026 While reset and the cycle after: wrRam_o=rdRam_o=0, halted_o=0, romAddr_o=0, ramAddr_o=0.
REQ-027 Reset in MEM aborts the access immediately; the pending ack is discarded, no acc/flag update.

Structure
REQ-028 Package cpu_mc_pkg SHALL hold opcode constants, FSM state encoding and flag bit indices.
REQ-029 Sub-module cpu_mc_alu SHALL be combinational: op, a, b -> result, Z, N, C.
REQ-030 Control FSM and datapath registers SHALL live in cpu_mc; no other sub-modules.

Verification
REQ-031 LDI 5; ADDI 3; STO 0x010; HLT, ack same cycle -> RAM[0x010]=8, acc_o=8, halted_o=1 after 9 cycles.
REQ-032 LDI 0x7FF (=-1); ADDI 1 -> acc=0, Z=1, C=1; SUBI 1 -> acc=0xFFFF, N=1, C=1.
REQ-033 LD 0x020 with 3-cycle delayed ack, RAM=0x1234 -> rdRam_o high 3 cycles, acc=0x1234, instruction takes 5 cycles.
REQ-034 BEQ taken/not-taken at pc=5 target 0x100 -> romAddr_o 0x100 / 6; JMP at pc=0x7FF with fallthrough wraps to 0.
REQ-035 Reset during MEM wait -> rdRam_o low next cycle, late ack ignored, fetch from pc=0, acc unchanged=0.
REQ-036 Opcode 20 at pc=3 -> NOP, pc=4, acc and flags unchanged.
